// File: rtl/ray_job_dispatcher.sv
// ray_job_dispatcher
// Feeds one ray-casting worker (lane LANE of N_WORKERS interleaved along x)
// with blocks of JOBS_SUBDIVISION pixels, then drains the worker's colour
// buffer into the framebuffer. Walks a full H_RES x V_RES frame per
// frame_start pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   frame_start     one-cycle pulse, accepted only in IDLE; latches sphere
//   sphere          scene sphere (only its y coordinate is consumed here)
//   activate/busy   worker handshake (see below)
//   pixel_start_x, pixel_y, pixel_y_sqrd, doty_r, sphere_y_sqrd
//                   per-block job parameters, registered in PREP
//   buffer          worker colour results, one entry per job pixel
//   fb_we/fb_addr/fb_data/fb_ready
//                   framebuffer write port (see below)
//   frame_done      one-cycle pulse at the end of the frame
//   error           sticky watchdog flag (0 unless the watchdog is built)
//   dbg_state       current FSM state, for checkers
//
// Handshakes:
//   activate/busy: activate rises in ARM; the worker raises busy to accept
//   the job, drops busy when its buffer is valid; activate then falls.
//   fb_we/fb_ready: a write transfers on a rising clock edge where both
//   are high; while fb_we=1 and fb_ready=0, fb_addr and fb_data hold.
//
// Build option: define RAY_DISPATCH_TIMEOUT_EN to add a 16-bit watchdog on
// ARM+RUN; after 4095 cycles it sets error, drops activate and drains the
// block as background colour.
`timescale 1ns/1ps

`ifndef RAY_JOB_DISPATCHER_DEFS
`define RAY_JOB_DISPATCHER_DEFS
`define FP_B             8
`define S_B              16
`define PX_Y_B           12
`define PX_Y_SQRD_B      24
`define DOT_Y_B          28
`define S_Y_SQRD_B       32
`define BACKGROUND_COLOR 12'h124
`endif

package Types;
  typedef logic [11:0] Color;
  // Only the part of the scene sphere the dispatcher consumes.
  typedef struct packed {
    logic signed [`S_B-1:0] y;
  } Sphere;
endpackage

module ray_job_dispatcher #(
  parameter int H_RES            = 640,
  parameter int V_RES            = 480,
  parameter int N_WORKERS        = 4,
  parameter int JOBS_SUBDIVISION = 8,
  parameter int LANE             = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  Types::Sphere                  sphere,
  output logic                          activate,
  output logic signed [11:0]            pixel_start_x,
  output logic signed [`PX_Y_B-1:0]     pixel_y,
  output logic [`PX_Y_SQRD_B-1:0]       pixel_y_sqrd,
  output logic signed [`DOT_Y_B-1:0]    doty_r,
  output logic [`S_Y_SQRD_B-1:0]        sphere_y_sqrd,
  input  logic                          busy,
  input  Types::Color                   buffer [JOBS_SUBDIVISION],
  output logic                          fb_we,
  output logic [18:0]                   fb_addr,
  output logic [11:0]                   fb_data,
  input  logic                          fb_ready,
  output logic                          frame_done,
  output logic                          error,
  output logic [2:0]                    dbg_state
);

  localparam int BLOCK_W = N_WORKERS * JOBS_SUBDIVISION;
  localparam int BLOCKS  = H_RES / BLOCK_W;
  localparam int KW      = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;

  typedef logic [KW-1:0] k_t;
  typedef logic signed [`PX_Y_B-1:0] py_t;
  typedef enum logic [2:0] {IDLE, PREP, ARM, RUN, DRAIN, NEXT, DONE} state_t;

  state_t                 state;
  Types::Color            copy [JOBS_SUBDIVISION];
  k_t                     k;
  k_t                     k_next;
  logic [11:0]            row;
  logic [11:0]            block;
  logic signed [`S_B-1:0] sph_y;
  logic                   timeout;

  py_t                           py_next;
  logic signed [`PX_Y_SQRD_B-1:0] py_sq;
  logic signed [`DOT_Y_B-1:0]    dot_y;
  logic signed [`S_Y_SQRD_B-1:0] sy_sq;
  logic [18:0]                   addr_base;

  assign dbg_state = state;
  assign k_next    = k + k_t'(1);

  // Row-relative job parameters; registered in PREP.
  assign py_next   = py_t'($signed({20'd0, row}) - V_RES / 2);
  assign py_sq     = py_next * py_next;
  assign dot_y     = py_next * sph_y;
  assign sy_sq     = (sph_y * sph_y) >>> `FP_B;

  // Address of entry 0 of the current block; later entries step by N_WORKERS.
  assign addr_base = 19'({20'd0, row} * 32'(H_RES) + {20'd0, block} * 32'(BLOCK_W) + 32'(LANE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      activate      <= 1'b0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_data       <= '0;
      frame_done    <= 1'b0;
      pixel_start_x <= '0;
      pixel_y       <= '0;
      pixel_y_sqrd  <= '0;
      doty_r        <= '0;
      sphere_y_sqrd <= '0;
      row           <= '0;
      block         <= '0;
      k             <= '0;
      sph_y         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            sph_y <= sphere.y;
            row   <= '0;
            block <= '0;
            state <= PREP;
          end
        end
        PREP: begin
          pixel_y       <= py_next;
          pixel_y_sqrd  <= $unsigned(py_sq);
          doty_r        <= dot_y;
          sphere_y_sqrd <= $unsigned(sy_sq);
          pixel_start_x <= 12'($signed({20'd0, block}) * BLOCK_W + LANE - H_RES / 2);
          activate      <= 1'b1;
          state         <= ARM;
        end
        ARM, RUN: begin
          if (timeout) begin
            // Worker never finished: abandon it and paint the block as background.
            activate <= 1'b0;
            fb_we    <= 1'b1;
            fb_addr  <= addr_base;
            fb_data  <= `BACKGROUND_COLOR;
            k        <= '0;
            for (int i = 0; i < JOBS_SUBDIVISION; i++) copy[i] <= `BACKGROUND_COLOR;
            state    <= DRAIN;
          end else if (state == ARM) begin
            if (busy) state <= RUN;
          end else if (!busy) begin
            // Snapshot the results so the worker may start reusing its buffer.
            activate <= 1'b0;
            copy     <= buffer;
            fb_we    <= 1'b1;
            fb_addr  <= addr_base;
            fb_data  <= buffer[0];
            k        <= '0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (fb_ready) begin
            if (k == k_t'(JOBS_SUBDIVISION - 1)) begin
              fb_we <= 1'b0;
              state <= NEXT;
            end else begin
              k       <= k_next;
              fb_addr <= fb_addr + 19'(N_WORKERS);
              fb_data <= copy[k_next];
            end
          end
        end
        NEXT: begin
          if (block == 12'(BLOCKS - 1)) begin
            block <= '0;
            row   <= row + 12'd1;
            if (row == 12'(V_RES - 1)) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= PREP;
            end
          end else begin
            block <= block + 12'd1;
            state <= PREP;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAY_DISPATCH_TIMEOUT_EN
  logic [15:0] wd;

  // wd counts completed ARM/RUN cycles; firing at 4094 ends the 4095th.
  assign timeout = (wd == 16'd4094);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd    <= '0;
      error <= 1'b0;
    end else begin
      if (state == ARM || state == RUN) wd <= wd + 16'd1;
      else                              wd <= '0;
      if ((state == ARM || state == RUN) && timeout) error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule
